sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl -- UART command decoder / system controller.
//
// Receives command frames byte by byte and drives a register file, an ALU
// and a TX FIFO:
//   0xAA addr data     : register file write
//   0xBB addr          : register file read, 1 result byte sent back
//   0xCC opA opB func  : write operands to RF[0]/RF[1], run ALU, 2 bytes back
//   0xDD func          : run ALU on current operands, 2 bytes back (LSB first)
// Any other first byte is dropped.
//
// Optional feature: define SYS_CTRL_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES REF_CLK cycles without a received byte.
//
// Ports
//   REF_CLK, RST                   clock, async active-low reset
//   RX_P_DATA, RX_D_VLD            received byte, one-cycle valid
//   RF_RdData, RF_RdData_VLD       register file read return
//   ALU_OUT, ALU_OUT_VLD           ALU result return
//   FIFO_FULL                      TX FIFO cannot accept a byte
//   RF_Address/WrData/WrEn/RdEn    register file access (registered)
//   ALU_FUN, ALU_EN, CLK_G_EN      ALU control and clock-gate enable
//   TX_P_DATA, TX_D_VLD            byte push to the TX FIFO
//   dbg_state_o                    current FSM state
//
// Handshake: RX_D_VLD, RF_RdData_VLD and ALU_OUT_VLD are single-cycle
// strobes with no back-pressure; TX_D_VLD is a single-cycle push that is only
// issued after FIFO_FULL was sampled low. Every output comes from a flop.
// -----------------------------------------------------------------------------
module sys_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    REF_CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_G_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic [3:0]              dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUNC, ALU_WAIT, TX_BYTE0, TX_BYTE1
  } state_e;

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                    rf_wren_q, rf_wren_d;
  logic                    rf_rden_q, rf_rden_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic                    clk_g_q, clk_g_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    two_byte_q, two_byte_d;
  logic                    to_hit;

  // States that are waiting for the next byte of a frame.
  logic in_rx_wait;
  assign in_rx_wait = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                      (state_q == RD_ADDR) || (state_q == OP_A) ||
                      (state_q == OP_B)    || (state_q == ALU_FUNC);

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter clears on every accepted byte and outside the waiting states.
  always_comb begin
    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (in_rx_wait && !RX_D_VLD) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    rf_wren_d  = 1'b0;
    rf_rden_d  = 1'b0;
    alu_fun_d  = alu_fun_q;
    alu_en_d   = alu_en_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = 1'b0;
    result_d   = result_q;
    two_byte_d = two_byte_q;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        if      (RX_P_DATA == CMD_WR)     state_d = WR_ADDR;
        else if (RX_P_DATA == CMD_RD)     state_d = RD_ADDR;
        else if (RX_P_DATA == CMD_ALU)    state_d = OP_A;
        else if (RX_P_DATA == CMD_ALU_NO) state_d = ALU_FUNC;
      end
      WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_wdata_d = RX_P_DATA;
        rf_wren_d  = 1'b1;
        state_d    = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        rf_rden_d = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_VLD) begin
        result_d   = {{DATA_WIDTH{1'b0}}, RF_RdData};
        two_byte_d = 1'b0;
        state_d    = TX_BYTE0;
      end
      OP_A: if (RX_D_VLD) begin
        rf_addr_d  = '0;
        rf_wdata_d = RX_P_DATA;
        rf_wren_d  = 1'b1;
        state_d    = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        rf_addr_d  = ADDR_WIDTH'(1);
        rf_wdata_d = RX_P_DATA;
        rf_wren_d  = 1'b1;
        state_d    = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d   = ALU_OUT;
        two_byte_d = 1'b1;
        alu_en_d   = 1'b0;
        state_d    = TX_BYTE0;
      end
      TX_BYTE0: if (!FIFO_FULL) begin
        tx_data_d = result_q[DATA_WIDTH-1:0];
        tx_vld_d  = 1'b1;
        state_d   = two_byte_q ? TX_BYTE1 : IDLE;
      end
      TX_BYTE1: if (!FIFO_FULL) begin
        tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_vld_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A timeout only fires when no byte arrived, so no side effect is pending.
    if (to_hit) state_d = IDLE;
    // Gate enable tracks the ALU phase; it drops after the ALU_OUT_VLD cycle.
    clk_g_d = (state_d == ALU_FUNC) || (state_d == ALU_WAIT);
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rf_wren_q  <= 1'b0;
      rf_rden_q  <= 1'b0;
      alu_fun_q  <= '0;
      alu_en_q   <= 1'b0;
      clk_g_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      result_q   <= '0;
      two_byte_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_wren_q  <= rf_wren_d;
      rf_rden_q  <= rf_rden_d;
      alu_fun_q  <= alu_fun_d;
      alu_en_q   <= alu_en_d;
      clk_g_q    <= clk_g_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      result_q   <= result_d;
      two_byte_q <= two_byte_d;
    end
  end

  assign RF_Address  = rf_addr_q;
  assign RF_WrData   = rf_wdata_q;
  assign RF_WrEn     = rf_wren_q;
  assign RF_RdEn     = rf_rden_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_G_EN    = clk_g_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl -- directed bench for sys_ctrl.
// Inputs are driven 1 ns after the rising edge; a monitor samples on the
// falling edge and logs RF writes, RF reads and TX pushes into queues that
// are compared against expected queues after each scenario.
// -----------------------------------------------------------------------------
module tb_sys_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          REF_CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic [DW-1:0] RF_RdData;
  logic          RF_RdData_VLD;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VLD;
  logic          FIFO_FULL;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic          RF_WrEn, RF_RdEn;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN, CLK_G_EN;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic [3:0]    dbg_state;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
    .REF_CLK(REF_CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_G_EN(CLK_G_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 REF_CLK = ~REF_CLK;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [AW+DW-1:0] wr_log[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW-1:0]    tx_log[$];
  logic [DW-1:0]    exp_q[$];
  int               rd_pulses = 0;
  int               rd_addr_last = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge REF_CLK) begin
    if (RST) begin
      if (RF_WrEn) wr_log.push_back({RF_Address, RF_WrData});
      if (RF_RdEn) begin
        rd_pulses++;
        rd_addr_last = int'(RF_Address);
      end
      if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
    end
  end

  task automatic check_logs(input string tag, input int exp_rd);
    check_eq({tag, " wr_count"}, wr_log.size(), exp_wr_q.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr_q.size(); i++)
      check_eq({tag, " wr_entry"}, wr_log[i], exp_wr_q[i]);
    check_eq({tag, " tx_count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++)
      check_eq({tag, " tx_byte"}, tx_log[i], exp_q[i]);
    check_eq({tag, " rd_count"}, rd_pulses, exp_rd);
    wr_log.delete(); exp_wr_q.delete(); tx_log.delete(); exp_q.delete();
    rd_pulses = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge REF_CLK); #1;
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge REF_CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic rf_return(input logic [DW-1:0] d);
    RF_RdData     = d;
    RF_RdData_VLD = 1'b1;
    @(posedge REF_CLK); #1;
    RF_RdData_VLD = 1'b0;
  endtask

  task automatic alu_return(input logic [2*DW-1:0] d);
    ALU_OUT     = d;
    ALU_OUT_VLD = 1'b1;
    @(posedge REF_CLK); #1;
    ALU_OUT_VLD = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0;
    RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
    idle(3);
    check_eq("reset_outputs",
             {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, CLK_G_EN, TX_P_DATA, TX_D_VLD},
             32'h0);
    RST = 1'b1;
    idle(2);
    check_eq("reset_state_idle", dbg_state, 4'd0);

    // RF write: AA 05 3C
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    check_eq("wr_pulse_now", RF_WrEn, 1'b1);
    idle(4);
    exp_wr_q.push_back({4'h5, 8'h3C});
    check_logs("rf_write", 0);

    // RF read: BB 05, RF returns 3C
    send_byte(8'hBB); send_byte(8'h05);
    check_eq("rd_pulse_now", RF_RdEn, 1'b1);
    check_eq("rd_address", RF_Address, 4'h5);
    idle(2);
    check_eq("rd_wait_no_tx", TX_D_VLD, 1'b0);
    send_byte(8'hAA);  // dropped while waiting for the RF
    rf_return(8'h3C);
    idle(5);
    check_eq("rd_addr_logged", rd_addr_last, 5);
    exp_q.push_back(8'h3C);
    check_logs("rf_read", 1);

    // ALU with operands: CC 10 20 00, ALU returns 0x0030
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20);
    check_eq("cc_clk_g_at_func", CLK_G_EN, 1'b1);
    check_eq("cc_alu_en_not_yet", ALU_EN, 1'b0);
    send_byte(8'h00);
    check_eq("cc_alu_en", ALU_EN, 1'b1);
    check_eq("cc_alu_fun", ALU_FUN, 4'h0);
    check_eq("cc_rf_wren_low", RF_WrEn, 1'b0);
    idle(3);
    alu_return(16'h0030);
    check_eq("cc_alu_en_dropped", ALU_EN, 1'b0);
    check_eq("cc_clk_g_dropped", CLK_G_EN, 1'b0);
    idle(6);
    exp_wr_q.push_back({4'h0, 8'h10});
    exp_wr_q.push_back({4'h1, 8'h20});
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h00);
    check_logs("alu_ops", 0);

    // Backpressure: DD 02, ALU returns 0x1234, FIFO full for 10 cycles
    FIFO_FULL = 1'b1;
    send_byte(8'hDD); send_byte(8'h02);
    check_eq("dd_alu_fun", ALU_FUN, 4'h2);
    check_eq("dd_alu_en", ALU_EN, 1'b1);
    idle(2);
    alu_return(16'h1234);
    idle(9);
    check_eq("bp_no_tx", tx_log.size(), 0);
    check_eq("bp_state_tx0", dbg_state, 4'd9);
    FIFO_FULL = 1'b0;
    idle(5);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    check_logs("backpressure", 0);

    // Illegal command
    send_byte(8'h55);
    check_eq("illegal_stays_idle", dbg_state, 4'd0);
    idle(3);
    check_logs("illegal", 0);

    // Reset mid-frame: AA 07 then reset
    send_byte(8'hAA); send_byte(8'h07);
    check_eq("mid_addr_latched", RF_Address, 4'h7);
    RST = 1'b0;
    #2;
    check_eq("midreset_outputs",
             {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, CLK_G_EN, TX_P_DATA, TX_D_VLD},
             32'h0);
    check_eq("midreset_state", dbg_state, 4'd0);
    @(posedge REF_CLK); #1;
    RST = 1'b1;
    idle(1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    idle(3);
    exp_wr_q.push_back({4'h1, 8'hFF});
    check_logs("after_reset", 0);

`ifdef SYS_CTRL_TIMEOUT_EN
    // Timeout: AA, 100 silent cycles, then 03 must be an illegal command
    send_byte(8'hAA);
    idle(100);
    check_eq("timeout_idle", dbg_state, 4'd0);
    send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    idle(3);
    exp_wr_q.push_back({4'h2, 8'h11});
    check_logs("timeout", 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
